uart_loader: RTL and testbench

//  Sequences the byte stream from the UART 8N1 receiver into framed memory-load

---
 rtl/uart_loader_if.sv | 13 +
 rtl/uart_loader.sv | 208 ++++++++++++++++++++
 tb/tb_uart_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// Memory write port of the boot loader: a word address, a 32-bit data word,
// and a write request that is held until the memory signals ready.
interface uart_loader_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_ready;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_ready);
endinterface

// File: rtl/uart_loader.sv
// Turns the UART byte stream (sync, header, data, checksum) into 32-bit memory
// writes for the boot path; holds the CPU via busy while a frame is loading.
module uart_loader #(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_done,
  input  logic [7:0]           rx_data,
  uart_loader_if.master        mem,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_err,
  output logic [1:0]           err_code
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;

  logic              byte_v;
  logic [7:0]        byte_b;
  logic [15:0]       a16;
  logic [15:0]       cnt_dec;
  logic              counting;
  logic              timeout;
  logic              fail;
  logic [1:0]        fail_code;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    xor_d     = xor_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    timer_d   = timer_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    fail      = 1'b0;
    fail_code = 2'd0;
    a16       = 16'(addr_q);
    cnt_dec   = cnt_q - 16'd1;
    counting  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);

    // A byte parked during WRITE is consumed first; a new strobe in the same cycle refills the skid.
    if (((state_q == S_DATA) || (state_q == S_CHK)) && pend_v_q) begin
      byte_v   = 1'b1;
      byte_b   = pend_q;
      pend_v_d = rx_done;
      if (rx_done) pend_d = rx_data;
    end else begin
      byte_v = rx_done;
      byte_b = rx_data;
    end

    if (rx_done)       timer_d = '0;
    else if (counting) timer_d = timer_q + 1'b1;
    timeout = counting && !byte_v && (timer_d == T_LAST);

    case (state_q)
      S_IDLE: begin
        if (rx_done && (rx_data == SYNC_BYTE)) begin
          state_d = S_HDR;
          code_d  = 2'd0;
          xor_d   = 8'h00;
          idx_d   = 2'd0;
        end
      end
      S_HDR: begin
        if (byte_v) begin
          xor_d = xor_q ^ byte_b;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    a16[7:0]  = byte_b;
            2'd1:    a16[15:8] = byte_b;
            2'd2:    cnt_d[7:0] = byte_b;
            default: begin
              cnt_d[15:8] = byte_b;
              state_d     = ({byte_b, cnt_q[7:0]} == 16'd0) ? S_CHK : S_DATA;
            end
          endcase
          addr_d = ADDR_W'(a16);
        end
      end
      S_DATA: begin
        if (byte_v) begin
          wdata_d[8*idx_q +: 8] = byte_b;
          xor_d = xor_q ^ byte_b;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (rx_done && pend_v_q) begin
          fail      = 1'b1;
          fail_code = 2'd3;
        end else begin
          if (rx_done) begin
            pend_d   = rx_data;
            pend_v_d = 1'b1;
          end
          if (mem.mem_ready) begin
            we_d    = 1'b0;
            cnt_d   = cnt_dec;
            addr_d  = addr_q + 1'b1;
            state_d = (cnt_dec == 16'd0) ? S_CHK : S_DATA;
          end
        end
      end
      S_CHK: begin
        if (byte_v) begin
          if (byte_b == xor_q) begin
            done_d = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = 2'd1;
          end
          state_d  = S_IDLE;
          pend_v_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      fail      = 1'b1;
      fail_code = 2'd2;
    end

    // Any abort returns to IDLE; words already written are left in memory.
    if (fail) begin
      err_d    = 1'b1;
      done_d   = 1'b0;
      code_d   = fail_code;
      we_d     = 1'b0;
      pend_v_d = 1'b0;
      state_d  = S_IDLE;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      we_q     <= 1'b0;
      cnt_q    <= 16'h0;
      xor_q    <= 8'h00;
      pend_q   <= 8'h00;
      pend_v_q <= 1'b0;
      timer_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      timer_q  <= timer_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign busy          = (state_q != S_IDLE);
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign err_code      = code_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: directed frames push expected writes and
// frame outcomes; a negedge monitor pops and compares whenever the DUT acts.
module tb_uart_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy, load_done, load_err;
  logic [1:0] err_code;

  uart_loader_if #(.ADDR_W(16)) mif ();

  uart_loader #(
    .ADDR_W     (16),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .mem      (mif.master),
    .busy     (busy),
    .load_done(load_done),
    .load_err (load_err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic done; logic [1:0] code; } ev_t;

  wr_t        wr_q[$];
  ev_t        ev_q[$];
  logic [7:0] fq[$];
  logic [7:0] acc;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [31:0] d);
    wr_q.push_back('{addr: a, data: d});
  endtask

  task automatic exp_ev(input logic done, input logic [1:0] code);
    ev_q.push_back('{done: done, code: code});
  endtask

  // One-cycle strobe; returns 1 ns after the edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_acc(input logic [7:0] b);
    send_byte(b);
    acc = acc ^ b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] flip);
    acc = 8'h00;
    send_byte(8'hA5);
    foreach (fq[i]) send_acc(fq[i]);
    send_byte(acc ^ flip);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mif.mem_we && mif.mem_ready) begin
        check("write_expected", 64'(wr_q.size() > 0), 64'd1);
        if (wr_q.size() > 0) begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", 64'(mif.mem_addr), 64'(w.addr));
          check("wr_data", 64'(mif.mem_wdata), 64'(w.data));
        end
      end
      if (load_done || load_err) begin
        check("pulse_exclusive", 64'(load_done & load_err), 64'd0);
        check("busy_at_pulse", 64'(busy), 64'd0);
        check("event_expected", 64'(ev_q.size() > 0), 64'd1);
        if (ev_q.size() > 0) begin
          ev_t e;
          e = ev_q.pop_front();
          check("ev_kind_done", 64'(load_done), 64'(e.done));
          check("ev_err_code", 64'(err_code), 64'(e.code));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mif.mem_ready = 1'b1;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_we", 64'(mif.mem_we), 64'd0);
    check("rst_addr", 64'(mif.mem_addr), 64'd0);
    check("rst_pulses", 64'({load_done, load_err}), 64'd0);
    check("rst_code", 64'(err_code), 64'd0);
    #11 rst_n = 1'b1;
    idle(2);

    // Good two-word frame at 0x0100
    fq = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    exp_wr(16'h0100, 32'h14131211);
    exp_wr(16'h0101, 32'h18171615);
    exp_ev(1'b1, 2'd0);
    send_frame(8'h00);
    check("t1_done_next_cycle", 64'(load_done), 64'd1);
    idle(3);
    check("t1_code", 64'(err_code), 64'd0);
    check("t1_writes_drained", 64'(wr_q.size()), 64'd0);

    // Same frame, corrupted checksum: writes still happen
    exp_wr(16'h0100, 32'h14131211);
    exp_wr(16'h0101, 32'h18171615);
    exp_ev(1'b0, 2'd1);
    send_frame(8'h01);
    check("t2_err_next_cycle", 64'(load_err), 64'd1);
    idle(3);
    check("t2_code_held", 64'(err_code), 64'd1);

    // Write stalled ~50 cycles, one byte parked in the skid register
    exp_wr(16'h0200, 32'h24232221);
    exp_wr(16'h0201, 32'h28272625);
    exp_ev(1'b1, 2'd0);
    acc = 8'h00;
    send_byte(8'hA5);
    send_acc(8'h00); send_acc(8'h02); send_acc(8'h02); send_acc(8'h00);
    send_acc(8'h21); send_acc(8'h22); send_acc(8'h23);
    mif.mem_ready = 1'b0;
    send_acc(8'h24);
    send_acc(8'h25);
    idle(45);
    check("t3_we_held", 64'(mif.mem_we), 64'd1);
    check("t3_addr_stable", 64'(mif.mem_addr), 64'h0200);
    check("t3_busy_stall", 64'(busy), 64'd1);
    mif.mem_ready = 1'b1;
    send_acc(8'h26); send_acc(8'h27); send_acc(8'h28);
    send_byte(acc);
    check("t3_done", 64'(load_done), 64'd1);

    // Two bytes during one stalled write -> overrun
    exp_ev(1'b0, 2'd3);
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    mif.mem_ready = 1'b0;
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
    send_byte(8'h35);
    check("t4_pend_still_busy", 64'(busy), 64'd1);
    send_byte(8'h36);
    check("t4_overrun_pulse", 64'(load_err), 64'd1);
    check("t4_busy_low", 64'(busy), 64'd0);
    check("t4_we_dropped", 64'(mif.mem_we), 64'd0);
    mif.mem_ready = 1'b1;
    idle(3);
    check("t4_code_held", 64'(err_code), 64'd3);

    // Timeout after ADDR_HI: error 99 edges after the edge sampling the last byte
    exp_ev(1'b0, 2'd2);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    n = 0;
    while (!load_err && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_timeout_latency", 64'(n), 64'd99);
    check("t5_code", 64'(err_code), 64'd2);
    send_byte(8'h00);
    check("t5_non_sync_ignored", 64'(busy), 64'd0);
    check("t5_code_until_sync", 64'(err_code), 64'd2);
    send_byte(8'hA5);
    check("t5_sync_restarts", 64'(busy), 64'd1);
    check("t5_sync_clears_code", 64'(err_code), 64'd0);
    // finish it as a zero-word frame: no write, load_done after CHK
    exp_ev(1'b1, 2'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    check("t6_cnt0_done", 64'(load_done), 64'd1);

    // Address wrap
    fq = '{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_wr(16'hFFFF, 32'h04030201);
    exp_wr(16'h0000, 32'h08070605);
    exp_ev(1'b1, 2'd0);
    send_frame(8'h00);
    check("t6_wrap_done", 64'(load_done), 64'd1);

    // Reset while a write is pending drops mem_we immediately
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h01); send_byte(8'h00);
    mif.mem_ready = 1'b0;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
    idle(3);
    check("t7_we_before_rst", 64'(mif.mem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_we_async_drop", 64'(mif.mem_we), 64'd0);
    check("t7_busy_async_drop", 64'(busy), 64'd0);
    idle(2);
    rst_n = 1'b1;
    mif.mem_ready = 1'b1;
    idle(5);
    check("t7_no_we_after_rst", 64'(mif.mem_we), 64'd0);

    check("end_writes_drained", 64'(wr_q.size()), 64'd0);
    check("end_events_drained", 64'(ev_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
